// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared opcode and FSM state encodings for seq_alu.
package seq_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_iter_step.sv
// alu_iter_step: one combinational iteration of the multi-cycle ALU.
//   MUL: shift-add. {acc, shreg} is the partial product with the multiplier
//        in shreg; if shreg[0] add b into acc, then shift the pair right.
//   DIV: restoring. acc is the partial remainder, shreg holds the dividend
//        being shifted out on the left and quotient bits shifted in on the right.
//   After W steps {acc, shreg} is the product, or {remainder, quotient}.
// Ports:
//   i_is_div  1  select DIV step (else MUL step)
//   i_acc     W  accumulator / partial remainder
//   i_shreg   W  multiplier / dividend-quotient shift register
//   i_b       W  multiplicand / divisor
//   o_acc     W  next accumulator
//   o_shreg   W  next shift register
module alu_iter_step #(
    parameter int W = 8
) (
    input  logic         i_is_div,
    input  logic [W-1:0] i_acc,
    input  logic [W-1:0] i_shreg,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_acc,
    output logic [W-1:0] o_shreg
);

    logic [W:0] w_sum;    // acc + b (or acc when multiplier bit is 0), with carry
    logic [W:0] w_rem;    // remainder shifted left with next dividend bit
    logic [W:0] w_trial;  // trial subtraction
    logic       w_q;

    always_comb begin
        w_sum   = {1'b0, i_acc} + (i_shreg[0] ? {1'b0, i_b} : '0);
        w_rem   = {i_acc, i_shreg[W-1]};
        w_trial = w_rem - {1'b0, i_b};
        w_q     = (w_rem >= {1'b0, i_b});
        if (i_is_div) begin
            // The remainder after a successful subtract is < b, so it fits W bits.
            o_acc   = w_q ? w_trial[W-1:0] : w_rem[W-1:0];
            o_shreg = {i_shreg[W-2:0], w_q};
        end else begin
            o_acc   = w_sum[W:1];
            o_shreg = {w_sum[0], i_shreg[W-1:1]};
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle unsigned integer ALU with start/busy/done handshake.
//   ADD/SUB and DIV-by-zero finish one cycle after accept; MUL/DIV iterate
//   for W cycles through alu_iter_step. result/dbz are only updated on the
//   edge that enters DONE and hold until the next completion.
// Ports:
//   clk     1   clock
//   rst     1   synchronous active-high reset
//   start   1   request, accepted when not busy (incl. the DONE cycle)
//   op      2   00 ADD, 01 SUB, 10 MUL, 11 DIV (sampled on accept)
//   a, b    W   unsigned operands (sampled on accept)
//   busy    1   high in RUN
//   done    1   one-cycle completion pulse
//   result  2W  result register
//   dbz     1   divide-by-zero flag, held with result
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           dbz
);

    localparam int CNT_W = $clog2(W) + 1;

    state_e           r_state;
    op_e              r_op;
    logic [W-1:0]     r_acc;
    logic [W-1:0]     r_shreg;
    logic [W-1:0]     r_b;
    logic [CNT_W-1:0] r_cnt;
    logic [2*W-1:0]   r_result;
    logic             r_dbz;

    logic             w_accept;
    logic [W:0]       w_add;   // bit W is the carry
    logic [W:0]       w_sub;   // bit W is the borrow (set iff a < b)
    logic [W-1:0]     w_acc_n;
    logic [W-1:0]     w_shreg_n;

    assign w_accept = start && (r_state != S_RUN);
    assign w_add    = {1'b0, a} + {1'b0, b};
    assign w_sub    = {1'b0, a} - {1'b0, b};

    alu_iter_step #(.W(W)) u_step (
        .i_is_div (r_op == OP_DIV),
        .i_acc    (r_acc),
        .i_shreg  (r_shreg),
        .i_b      (r_b),
        .o_acc    (w_acc_n),
        .o_shreg  (w_shreg_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= OP_ADD;
            r_acc    <= '0;
            r_shreg  <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        case (op_e'(op))
                            OP_ADD: begin
                                r_result <= {{(W-1){1'b0}}, w_add};
                                r_dbz    <= 1'b0;
                                r_state  <= S_DONE;
                            end
                            OP_SUB: begin
                                r_result <= {{(W-1){1'b0}}, w_sub};
                                r_dbz    <= 1'b0;
                                r_state  <= S_DONE;
                            end
                            OP_MUL, OP_DIV: begin
                                if (op_e'(op) == OP_DIV && b == '0) begin
                                    r_result <= {a, {W{1'b1}}};
                                    r_dbz    <= 1'b1;
                                    r_state  <= S_DONE;
                                end else begin
                                    r_op    <= op_e'(op);
                                    r_acc   <= '0;
                                    r_shreg <= a;
                                    r_b     <= b;
                                    r_cnt   <= '0;
                                    r_state <= S_RUN;
                                end
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_n;
                    r_shreg <= w_shreg_n;
                    r_cnt   <= r_cnt + 1'b1;
                    // Last step: publish straight from the step outputs so
                    // no partial value ever reaches result.
                    if (r_cnt == CNT_W'(W - 1)) begin
                        r_result <= {w_acc_n, w_shreg_n};
                        r_dbz    <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign dbz    = r_dbz;

endmodule
